// File: rtl/approx_mult_pkg.sv
// Shared definitions for the sequenced approximate multiplier.
//   WIDTH          operand width in bits
//   ROWS_PER_PASS  partial-product rows reduced per pass by the shared slice
//   NPASS          passes needed to cover all WIDTH rows
//   TRUNC_W        width of the truncation-column count
//   state_t        controller FSM states
//   pp_keep        whether partial-product bit (i, j) survives truncation
package approx_mult_pkg;

   localparam int unsigned WIDTH         = 16;
   localparam int unsigned ROWS_PER_PASS = 8;
   localparam int unsigned NPASS         = WIDTH / ROWS_PER_PASS;
   localparam int unsigned TRUNC_W       = 5;
   localparam int unsigned PASS_W        = (NPASS > 1) ? $clog2(NPASS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      OUT
   } state_t;

   // Bit pp[i][j] has weight 2^(i+j); columns below trunc are dropped.
   function automatic logic pp_keep(input int unsigned i, input int unsigned j,
                                    input logic [TRUNC_W-1:0] trunc);
      return (i + j) >= 32'(trunc);
   endfunction

endpackage

// File: rtl/pp_reduce_slice.sv
// Combinational partial-product reduction slice.
// Builds ROWS_PER_PASS masked, shifted partial-product rows selected by
// pass_idx, compresses them to two vectors with a carry-save tree (8:2) and
// resolves them with a final adder.
//   a, b      latched operands
//   trunc     number of low result columns to drop
//   pass_idx  selects rows pass_idx*ROWS_PER_PASS .. +ROWS_PER_PASS-1
//   sum       exact sum of the selected retained rows
module pp_reduce_slice
   import approx_mult_pkg::*;
(
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [TRUNC_W-1:0] trunc,
   input  logic [PASS_W-1:0]  pass_idx,
   output logic [2*WIDTH-1:0] sum
);

   localparam int unsigned PW = 2 * WIDTH;

   function automatic logic [WIDTH-1:0] keep_mask(input int unsigned row,
                                                 input logic [TRUNC_W-1:0] t);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         m = m | (WIDTH'(pp_keep(row, j, t)) << j);
      end
      return m;
   endfunction

   // 3:2 compressor across all columns: returns {carry, sum}, carry pre-shifted.
   function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                           input logic [PW-1:0] z);
      logic [PW-1:0] s;
      logic [PW-1:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   logic [PW-1:0]    rows [ROWS_PER_PASS];
   logic [WIDTH-1:0] b_sh;
   int unsigned      row_i;

   always_comb begin
      b_sh  = '0;
      row_i = 0;
      for (int unsigned k = 0; k < ROWS_PER_PASS; k++) begin
         row_i   = 32'(pass_idx) * ROWS_PER_PASS + k;
         b_sh    = b >> row_i;
         rows[k] = b_sh[0] ? ({{WIDTH{1'b0}}, a & keep_mask(row_i, trunc)} << row_i) : '0;
      end
   end

   // Fixed 8 -> 6 -> 4 -> 3 -> 2 carry-save tree for ROWS_PER_PASS = 8.
   // The full sum of one pass fits in PW bits, so dropped carries are zero.
   logic [PW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

   assign {c0, s0} = csa(rows[0], rows[1], rows[2]);
   assign {c1, s1} = csa(rows[3], rows[4], rows[5]);
   assign {c2, s2} = csa(s0, c0, s1);
   assign {c3, s3} = csa(c1, rows[6], rows[7]);
   assign {c4, s4} = csa(s2, c2, s3);
   assign {c5, s5} = csa(s4, c4, c3);
   assign sum      = s5 + c5;

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Sequenced 16x16 unsigned approximate multiplier controller.
// Latches an operand set on accept, runs NPASS passes through the shared
// reduction slice accumulating into acc, then presents the product until the
// consumer takes it.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (ready only in IDLE)
//   a, b            unsigned operands
//   trunc_cols      low result columns whose partial-product bits are dropped
//   out_valid/ready product handshake
//   product         approximate product
//   busy            high whenever not IDLE
module approx_mult_seq_ctrl
   import approx_mult_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [TRUNC_W-1:0] trunc_cols,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NPASS - 1);

   state_t               state, state_next;
   logic [PASS_W-1:0]    pass_idx;
   logic [WIDTH-1:0]     a_r, b_r;
   logic [TRUNC_W-1:0]   trunc_r;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   slice_sum;

   pp_reduce_slice u_slice (
      .a        (a_r),
      .b        (b_r),
      .trunc    (trunc_r),
      .pass_idx (pass_idx),
      .sum      (slice_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Handshake outputs decode state only; in_valid/out_ready steer next state.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_next = REDUCE;
         end
         REDUCE: begin
            if (pass_idx == LAST_PASS) state_next = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_idx <= '0;
         a_r      <= '0;
         b_r      <= '0;
         trunc_r  <= '0;
         acc      <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            a_r      <= a;
            b_r      <= b;
            trunc_r  <= trunc_cols;
            pass_idx <= '0;
         end
         if (state == REDUCE) begin
            acc      <= ((pass_idx == '0) ? '0 : acc) + slice_sum;
            pass_idx <= (pass_idx == LAST_PASS) ? '0 : pass_idx + 1'b1;
         end
      end
   end

   assign product = acc;

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
module tb_approx_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [4:0]  trunc_cols = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] product;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   approx_mult_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .trunc_cols (trunc_cols),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .product    (product),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference: sum of a[j]*b[i]*2^(i+j) over i+j >= trunc, mod 2^32.
   function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                            input int t);
      longint s;
      s = 0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            if (y[i] && x[j] && (i + j) >= t) s = s + (longint'(1) << (i + j));
      return s[31:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: issue one op with out_ready high; report product and
   // cycles from the accept edge until out_valid was seen.
   task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic [4:0] tv,
                        output logic [31:0] prod, output int lat, output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin step(); n++; end
      a = av; b = bv; trunc_cols = tv; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
      prod = product;
      ok   = out_valid;
      step();
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h want 1 0 0 0",
                  in_ready, out_valid, busy, product);
      end
      step(); step();
      rst = 1'b0;
      step();
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_exact_max();
      a = 16'hFFFF; b = 16'hFFFF; trunc_cols = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
      step();  // accept edge E0
      in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL after_accept: in_ready=%b busy=%b out_valid=%b want 0 1 0",
                  in_ready, busy, out_valid);
      end
      step();  // E1
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL early_valid: out_valid=%b at E1 want 0", out_valid);
      end
      step();  // E2
      n_cmp++;
      if (out_valid !== 1'b1 || product !== 32'hFFFE0001) begin
         n_fail++;
         $display("FAIL exact_max: out_valid=%b product=%h want 1 fffe0001", out_valid, product);
      end
      step();  // handshake edge
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL return_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                  in_ready, out_valid, busy);
      end
   endtask

   task automatic test_trunc();
      logic [31:0] p;
      logic [15:0] ra, rb;
      int          lat;
      bit          ok;
      do_op(16'hFFFF, 16'h0001, 5'd4, p, lat, ok);
      n_cmp++;
      if (!ok || p !== 32'h0000FFF0 || lat != 2) begin
         n_fail++;
         $display("FAIL trunc4: ok=%0d product=%h lat=%0d want 1 0000fff0 2", ok, p, lat);
      end
      do_op(16'hFFFF, 16'hFFFF, 5'd31, p, lat, ok);
      n_cmp++;
      if (!ok || p !== 32'h0) begin
         n_fail++;
         $display("FAIL trunc31: ok=%0d product=%h want 0", ok, p);
      end
      for (int k = 0; k < 4; k++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         do_op(ra, rb, 5'(8 + 4 * k), p, lat, ok);
         n_cmp++;
         if (!ok || p !== ref_prod(ra, rb, 8 + 4 * k)) begin
            n_fail++;
            $display("FAIL trunc_rand: a=%h b=%h t=%0d product=%h want %h",
                     ra, rb, 8 + 4 * k, p, ref_prod(ra, rb, 8 + 4 * k));
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      a = 16'h1234; b = 16'h5678; trunc_cols = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
      step();
      n = 0;
      while (!out_valid && n < 10) begin step(); n++; end
      for (int c = 0; c < 6; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || product !== 32'h06260060 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: out_valid=%b product=%h in_ready=%b want 1 06260060 0",
                     c, out_valid, product, in_ready);
         end
         step();
      end
      out_ready = 1'b1; in_valid = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                  out_valid, in_ready, busy);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] p;
      int          lat;
      bit          ok;
      a = 16'hABCD; b = 16'h1357; trunc_cols = 5'd0; in_valid = 1'b1;
      step();  // accepted, now in pass 0
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || product !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: out_valid=%b product=%h busy=%b in_ready=%b want 0 0 0 1",
                  out_valid, product, busy, in_ready);
      end
      step();
      rst = 1'b0;
      step();
      do_op(16'd3, 16'd5, 5'd0, p, lat, ok);
      n_cmp++;
      if (!ok || p !== 32'd15) begin
         n_fail++;
         $display("FAIL after_reset_op: ok=%0d product=%0d want 15", ok, p);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q[$];
      logic [31:0] e;
      int sent, got, cyc;
      bit acc_now;
      sent = 0; got = 0; cyc = 0;
      a = 16'($urandom); b = 16'($urandom); trunc_cols = 5'($urandom_range(0, 31));
      in_valid = 1'b1;
      while (got < 100 && cyc < 5000) begin
         out_ready = 1'($urandom);
         acc_now   = in_valid && in_ready;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_extra: unexpected product %h", product);
            end else begin
               e = exp_q.pop_front();
               if (product !== e) begin
                  n_fail++;
                  $display("FAIL b2b_product[%0d]: got %h want %h", got, product, e);
               end
            end
            got++;
         end
         if (acc_now) begin
            exp_q.push_back(ref_prod(a, b, int'(trunc_cols)));
            sent++;
         end
         step();
         cyc++;
         if (acc_now) begin
            a = 16'($urandom); b = 16'($urandom); trunc_cols = 5'($urandom_range(0, 31));
            if (sent >= 100) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if (got != 100 || sent != 100 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d want 100 100 0",
                  sent, got, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_exact_max();
      test_trunc();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
